// File: rtl/p_comp_pkg.sv
`default_nettype none
// ============================================================================
// Module   : p_comp_pkg
// Brief    : Shared constants, FSM state type and LFSR step for the p-bit sampler.
// Revision : 1.0 - initial release
// ============================================================================
package p_comp_pkg;

    localparam int ACT_W   = 4;
    localparam int ACT_MID = 8;
    localparam int ACT_MAX = 15;
    localparam int LFSR_W  = 16;

    localparam logic [LFSR_W-1:0] LFSR_POLY    = 16'hB400;
    localparam logic [LFSR_W-1:0] DEFAULT_SEED = 16'hACE1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SAMPLE = 2'd1,
        SETTLE = 2'd2
    } state_t;

    // Galois form, shifting right: the bit falling out of bit 0 folds the taps back in.
    function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_POLY : '0);
    endfunction

endpackage
`default_nettype wire

// File: rtl/p_lfsr.sv
`default_nettype none
// ============================================================================
// Module   : p_lfsr
// Brief    : 16-bit Galois LFSR with advance, load and zero-seed substitution.
// Revision : 1.0 - initial release
// ============================================================================
module p_lfsr
    import p_comp_pkg::*;
#(
    parameter logic [LFSR_W-1:0] SEED = DEFAULT_SEED
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_advance,
    input  logic              i_load,
    input  logic [LFSR_W-1:0] i_load_val,
    output logic [LFSR_W-1:0] o_value
);

    logic [LFSR_W-1:0] r_value;

    // A zero state would lock up the register, so a zero load falls back to SEED.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_value <= SEED;
        end else if (i_load) begin
            r_value <= (i_load_val == '0) ? SEED : i_load_val;
        end else if (i_advance) begin
            r_value <= lfsr_step(r_value);
        end
    end

    assign o_value = r_value;

endmodule
`default_nettype wire

// File: rtl/p_bit_sampler.sv
`default_nettype none
// ============================================================================
// Module   : p_bit_sampler
// Brief    : Sequential Gibbs-update p-bit array driven by LFSR random nibbles.
//            Optional clamp ports enabled by macro PBIT_CLAMP_EN.
// Revision : 1.0 - initial release
// ============================================================================
module p_bit_sampler
    import p_comp_pkg::*;
#(
    parameter int          N_PBITS       = 5,
    parameter int          ACT_W         = 4,
    parameter int          SETTLE_CYCLES = 1,
    parameter logic [15:0] SEED          = 16'hACE1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       run,
    input  logic [ACT_W*N_PBITS-1:0]   act_in,
    input  logic                       seed_load,
    input  logic [15:0]                seed_val,
`ifdef PBIT_CLAMP_EN
    input  logic [N_PBITS-1:0]         clamp_mask,
    input  logic [N_PBITS-1:0]         clamp_val,
`endif
    output logic [N_PBITS-1:0]         spins,
    output logic                       busy,
    output logic                       sweep_done,
    output logic [15:0]                sweep_count
);

    localparam int IDX_W = (N_PBITS > 1) ? $clog2(N_PBITS) : 1;

    state_t               r_state, w_state_nxt;
    logic [N_PBITS-1:0]   r_spins, w_spins_nxt;
    logic [IDX_W-1:0]     r_idx, w_idx_nxt;
    logic [2:0]           r_cnt, w_cnt_nxt;
    logic [15:0]          r_sweep_count, w_count_nxt;
    logic                 w_advance;
    logic                 w_sweep_end;
    logic                 w_sample;
    logic [15:0]          w_lfsr;
    logic [ACT_W-1:0]     w_act;

    p_lfsr #(
        .SEED       (SEED)
    ) u_lfsr (
        .clk        (clk),
        .rst        (rst),
        .i_advance  (w_advance),
        .i_load     (seed_load),
        .i_load_val (seed_val),
        .o_value    (w_lfsr)
    );

    assign w_act    = act_in[int'(r_idx)*ACT_W +: ACT_W];
    assign w_sample = (w_act > ACT_W'(w_lfsr[3:0]));

    always_comb begin
        w_state_nxt = r_state;
        w_spins_nxt = r_spins;
        w_idx_nxt   = r_idx;
        w_cnt_nxt   = r_cnt;
        w_count_nxt = r_sweep_count;
        w_advance   = 1'b0;
        w_sweep_end = 1'b0;
        case (r_state)
            IDLE: begin
                if (run) begin
                    w_state_nxt = SAMPLE;
                    w_idx_nxt   = '0;
                end
            end
            SAMPLE: begin
                w_spins_nxt[r_idx] = w_sample;
`ifdef PBIT_CLAMP_EN
                if (clamp_mask[r_idx]) begin
                    w_spins_nxt[r_idx] = clamp_val[r_idx];
                end
`endif
                w_advance   = 1'b1;
                w_cnt_nxt   = 3'(SETTLE_CYCLES - 1);
                w_state_nxt = SETTLE;
            end
            SETTLE: begin
                if (r_cnt != 3'd0) begin
                    w_cnt_nxt = r_cnt - 3'd1;
                end else if (r_idx != IDX_W'(N_PBITS - 1)) begin
                    w_idx_nxt   = r_idx + IDX_W'(1);
                    w_state_nxt = SAMPLE;
                end else begin
                    w_sweep_end = 1'b1;
                    w_count_nxt = r_sweep_count + 16'd1;
                    w_idx_nxt   = '0;
                    w_state_nxt = run ? SAMPLE : IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
`ifdef PBIT_CLAMP_EN
        if (r_state == IDLE) begin
            w_spins_nxt = (r_spins & ~clamp_mask) | (clamp_val & clamp_mask);
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= IDLE;
            r_spins       <= '0;
            r_idx         <= '0;
            r_cnt         <= '0;
            r_sweep_count <= '0;
        end else begin
            r_state       <= w_state_nxt;
            r_spins       <= w_spins_nxt;
            r_idx         <= w_idx_nxt;
            r_cnt         <= w_cnt_nxt;
            r_sweep_count <= w_count_nxt;
        end
    end

    // Pulse spans the final SETTLE cycle, so busy drops one cycle after it;
    // a reset in that cycle suppresses it.
    assign sweep_done  = w_sweep_end & ~rst;
    assign busy        = (r_state != IDLE);
    assign spins       = r_spins;
    assign sweep_count = r_sweep_count;

endmodule
`default_nettype wire

// File: tb/tb_p_bit_sampler.sv
`default_nettype none
// ============================================================================
// Module   : tb_p_bit_sampler
// Brief    : Scoreboard bench for p_bit_sampler against a sweep-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_p_bit_sampler;

    localparam int N = 5;

    typedef struct {
        logic [N-1:0] spins;
        logic [15:0]  cnt;
    } exp_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          run = 1'b0;
    logic          seed_load = 1'b0;
    logic [15:0]   seed_val = 16'd0;
    logic [4*N-1:0] act_in;
    logic [N-1:0]  spins;
    logic          busy;
    logic          sweep_done;
    logic [15:0]   sweep_count;
`ifdef PBIT_CLAMP_EN
    logic [N-1:0]  clamp_mask = '0;
    logic [N-1:0]  clamp_val  = '0;
`endif

    int            mode = 0;
    logic [4*N-1:0] base = '0;
    int            total = 0;
    int            bad = 0;
    int            ones [N];
    int            diff01 = 0;
    exp_t          q [$];

    logic [15:0]   m_lfsr  = 16'hACE1;
    logic [N-1:0]  m_spins = '0;
    logic [15:0]   m_count = 16'd0;

    always #5 clk = ~clk;

    // Mode 1 wires an inverting coupling between p-bits 0 and 1.
    function automatic logic [4*N-1:0] act_vec(input int md, input logic [N-1:0] s,
                                               input logic [4*N-1:0] b);
        logic [4*N-1:0] a;
        a = b;
        if (md == 1) begin
            a[3:0] = s[1] ? 4'd2 : 4'd13;
            a[7:4] = s[0] ? 4'd2 : 4'd13;
        end
        return a;
    endfunction

    assign act_in = act_vec(mode, spins, base);

    p_bit_sampler dut (
        .clk         (clk),
        .rst         (rst),
        .run         (run),
        .act_in      (act_in),
        .seed_load   (seed_load),
        .seed_val    (seed_val),
`ifdef PBIT_CLAMP_EN
        .clamp_mask  (clamp_mask),
        .clamp_val   (clamp_val),
`endif
        .spins       (spins),
        .busy        (busy),
        .sweep_done  (sweep_done),
        .sweep_count (sweep_count)
    );

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, got, want);
        end
    endtask

    task automatic check_range(input string name, input int val, input int lo, input int hi);
        total++;
        if (val < lo || val > hi) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d..%0d", name, val, lo, hi);
        end
    endtask

    function automatic logic [15:0] lstep(input logic [15:0] v);
        return v[0] ? ((v >> 1) ^ 16'hB400) : (v >> 1);
    endfunction

    // One full sweep of the reference: each p-bit in turn draws the low nibble.
    task automatic model_sweep();
        logic [4*N-1:0] a;
        logic [3:0]     nib;
        logic           b;
        for (int i = 0; i < N; i++) begin
            a   = act_vec(mode, m_spins, base);
            nib = a[4*i +: 4];
            b   = (nib > m_lfsr[3:0]);
`ifdef PBIT_CLAMP_EN
            if (clamp_mask[i]) b = clamp_val[i];
`endif
            m_spins[i] = b;
            m_lfsr     = lstep(m_lfsr);
        end
        q.push_back('{spins: m_spins, cnt: m_count});
        m_count = m_count + 16'd1;
    endtask

    task automatic run_phase(input int n);
        int got, lat, since;
        got = 0; lat = 0; since = 0;
`ifdef PBIT_CLAMP_EN
        m_spins = (m_spins & ~clamp_mask) | (clamp_val & clamp_mask);
`endif
        for (int k = 0; k < n; k++) model_sweep();
        @(negedge clk);
        run = 1'b1;
        for (int c = 0; c < n * 20 + 40 && got < n; c++) begin
            @(negedge clk);
            lat++;
            if (sweep_done) begin
                if (got == 0) check("first_done_latency", lat, 10);
                got++;
                if (got == n) check("busy_at_last_done", busy, 1);
            end
            if (got >= n - 1) since++;
            if (since == 3) run = 1'b0;
        end
        run = 1'b0;
        check("sweeps_seen", got, n);
        @(negedge clk);
        check("busy_after_done", busy, 0);
        check("final_spins", spins, m_spins);
        check("final_count", sweep_count, m_count);
        check("queue_drained", q.size(), 0);
    endtask

    task automatic load_seed(input logic [15:0] v);
        @(negedge clk);
        seed_load = 1'b1;
        seed_val  = v;
        @(negedge clk);
        seed_load = 1'b0;
        m_lfsr = (v == 16'd0) ? 16'hACE1 : v;
    endtask

    // Monitor: compares every sweep_done against the scoreboard queue.
    initial begin
        exp_t e;
        for (int i = 0; i < N; i++) ones[i] = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                if (sweep_done) check("done_in_reset", sweep_done, 0);
            end else if (sweep_done) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_done: got pulse expected none");
                end else begin
                    e = q.pop_front();
                    check("sweep_spins", spins, e.spins);
                    check("sweep_count_pre", sweep_count, e.cnt);
                end
                for (int i = 0; i < N; i++) ones[i] += spins[i];
                if (spins[0] != spins[1]) diff01++;
            end
        end
    end

    initial begin
        int o0 [N];
        int d0;
        repeat (3) @(negedge clk);
        check("rst_spins", spins, 0);
        check("rst_busy", busy, 0);
        check("rst_done", sweep_done, 0);
        check("rst_count", sweep_count, 0);
        rst = 1'b0;

        // All-zero activations.
        load_seed(16'd0);
        mode = 0; base = '0;
        run_phase(1);
        check("zero_act_spins", spins, 0);

        // Saturated high.
        base = {N{4'hF}};
        o0 = ones;
        run_phase(64);
        for (int i = 0; i < N; i++) check_range("sat_ones", ones[i] - o0[i], 52, 64);

        // Statistical midpoint from a random seed.
        load_seed(16'($urandom_range(1, 65535)));
        base = {N{4'h8}};
        o0 = ones;
        run_phase(1024);
        for (int i = 0; i < N; i++) check_range("mid_ones", ones[i] - o0[i], 448, 576);

        // Inverting coupling between p-bits 0 and 1.
        mode = 1; base = 20'($urandom);
        d0 = diff01;
        run_phase(512);
        check_range("not_loop_diff", diff01 - d0, 257, 512);
        mode = 0;

        // Random activations with short sweeps, including run dropped in sweep 2.
        for (int r = 0; r < 6; r++) begin
            base = 20'($urandom);
            run_phase((r == 0) ? 2 : $urandom_range(1, 4));
        end

        // Zero seed falls back to the default.
        load_seed(16'd0);
        base = 20'($urandom);
        run_phase(2);

`ifdef PBIT_CLAMP_EN
        clamp_mask = 5'b00100;
        clamp_val  = 5'b00100;
        base = 20'($urandom) & ~20'h00F00;
        o0 = ones;
        run_phase(8);
        check("clamp_ones", ones[2] - o0[2], 8);
        clamp_mask = '0;
        clamp_val  = '0;
        base = 20'($urandom);
        run_phase(3);
`endif

        // Reset in the middle of the second sweep.
        base = 20'($urandom);
        model_sweep();
        @(negedge clk);
        run = 1'b1;
        repeat (13) @(negedge clk);
        rst = 1'b1;
        run = 1'b0;
        check("rst_mid_done", sweep_done, 0);
        @(negedge clk);
        check("rst_mid_spins", spins, 0);
        check("rst_mid_count", sweep_count, 0);
        check("rst_mid_busy", busy, 0);
        check("rst_mid_queue", q.size(), 0);
        q.delete();
        rst = 1'b0;
        m_lfsr = 16'hACE1; m_spins = '0; m_count = 16'd0;

        base = 20'($urandom);
        run_phase(3);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
